// File: rtl/vpe_pkg.sv
// Shared constants and arithmetic helpers for the VPE requantization stage.
package vpe_pkg;

    localparam int unsigned PSUM_WIDTH_DEF  = 32;
    localparam int unsigned O_WIDTH_DEF     = 8;
    localparam int unsigned BATCH_SIZE_DEF  = 16;
    localparam int unsigned SHIFT_WIDTH_DEF = 5;
    localparam int unsigned ACC_W           = 64;
    localparam int unsigned STAT_W          = 16;

    typedef struct packed {
        logic signed [ACC_W-1:0] value;
        logic                    ovf;
    } sat_res_t;

    // Round half up, then arithmetic right shift.
    function automatic logic signed [ACC_W-1:0] round_shift(
        input logic signed [ACC_W-1:0] value,
        input int unsigned             shift
    );
        logic signed [ACC_W-1:0] biased;
        biased = value;
        if (shift != 0) begin
            biased = value + (64'sd1 <<< (shift - 1));
        end
        return biased >>> shift;
    endfunction

    // Clamp to a signed range of the given width and flag the clamp.
    function automatic sat_res_t sat_signed(
        input logic signed [ACC_W-1:0] value,
        input int unsigned             width
    );
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        sat_res_t                r;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        r.ovf = 1'b1;
        if (value > hi) begin
            r.value = hi;
        end else if (value < lo) begin
            r.value = lo;
        end else begin
            r.value = value;
            r.ovf   = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/vpe_requant_stage_if.sv
// Input partial-sum stream and output requantized stream of the stage.
interface vpe_requant_stage_if
    import vpe_pkg::*;
#(
    parameter int unsigned PSUM_WIDTH = PSUM_WIDTH_DEF,
    parameter int unsigned O_WIDTH    = O_WIDTH_DEF,
    parameter int unsigned IDX_W      = $clog2(BATCH_SIZE_DEF)
);
    logic                  in_valid;
    logic                  in_ready;
    logic [PSUM_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [O_WIDTH-1:0]    out_data;
    logic [IDX_W-1:0]      out_idx;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx
    );
endinterface

// File: rtl/vpe_elastic_reg.sv
// Single valid/ready pipeline register with synchronous flush.
module vpe_elastic_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready_c,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    assign in_ready_c = !valid_q || out_ready;
    assign out_valid  = valid_q;
    assign out_data   = data_q;

    // Load when the slot is free or draining; otherwise hold the payload.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (in_ready_c) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    // Slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: rtl/vpe_requant_stage.sv
// Bias add, rounding shift, optional ReLU and saturation of the psum stream.
// Optional saturation counter enabled by defining VPE_REQUANT_STATS_EN.
module vpe_requant_stage
    import vpe_pkg::*;
#(
    parameter int unsigned PSUM_WIDTH  = PSUM_WIDTH_DEF,
    parameter int unsigned O_WIDTH     = O_WIDTH_DEF,
    parameter int unsigned BATCH_SIZE  = BATCH_SIZE_DEF,
    parameter int unsigned SHIFT_WIDTH = SHIFT_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_clear,
    input  logic [SHIFT_WIDTH-1:0]        cfg_shift,
    input  logic                          cfg_relu_en,
    input  logic                          bias_wr_en,
    input  logic [$clog2(BATCH_SIZE)-1:0] bias_wr_idx,
    input  logic [PSUM_WIDTH-1:0]         bias_wr_data,
    vpe_requant_stage_if.slave            bus,
    output logic                          sat_flag,
    input  logic                          sat_clear,
    output logic [STAT_W-1:0]             sat_count
);
    localparam int unsigned IDX_W = $clog2(BATCH_SIZE);
    localparam int unsigned SUM_W = PSUM_WIDTH + 1;

    typedef struct packed {
        logic signed [SUM_W-1:0] sum;
        logic [IDX_W-1:0]        idx;
        logic [SHIFT_WIDTH-1:0]  shift;
        logic                    relu;
    } s1_t;

    typedef struct packed {
        logic [O_WIDTH-1:0] data;
        logic [IDX_W-1:0]   idx;
        logic               sat;
    } s2_t;

    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [PSUM_WIDTH-1:0] bias_q [BATCH_SIZE];
    logic [PSUM_WIDTH-1:0] bias_d [BATCH_SIZE];
    logic                  sat_flag_q, sat_flag_d;

    s1_t  s1_in_c, s1_pl;
    s2_t  s2_in_c, s2_pl;
    logic s1_ready_c, s1_valid, s2_ready_c;
    logic accept_c, sat_evt_c;

    // Shift, clamp and saturate one stage-1 beat into the stage-2 payload.
    function automatic s2_t requant(input s1_t b);
        logic signed [ACC_W-1:0] shifted;
        sat_res_t                r;
        s2_t                     o;
        shifted = round_shift(ACC_W'($signed(b.sum)), 32'(b.shift));
        if (b.relu && shifted[ACC_W-1]) begin
            shifted = '0;
        end
        r      = sat_signed(shifted, O_WIDTH);
        o.data = O_WIDTH'(r.value);
        o.idx  = b.idx;
        o.sat  = r.ovf;
        return o;
    endfunction

    assign bus.in_ready = rst_n && !frame_clear && s1_ready_c;
    assign accept_c     = bus.in_valid && bus.in_ready;
    assign sat_evt_c    = bus.out_valid && bus.out_ready && s2_pl.sat;
    assign bus.out_data = s2_pl.data;
    assign bus.out_idx  = s2_pl.idx;
    assign sat_flag     = sat_flag_q;

    // Stage-1 payload: widened bias add plus the beat's own config snapshot.
    always_comb begin
        s1_in_c       = '0;
        s1_in_c.sum   = SUM_W'($signed(bus.in_data)) + SUM_W'($signed(bias_q[idx_q]));
        s1_in_c.idx   = idx_q;
        s1_in_c.shift = cfg_shift;
        s1_in_c.relu  = cfg_relu_en;
        s2_in_c       = requant(s1_pl);
    end

    vpe_elastic_reg #(.WIDTH($bits(s1_t))) u_s1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (frame_clear),
        .in_valid   (bus.in_valid && !frame_clear),
        .in_data    (s1_in_c),
        .in_ready_c (s1_ready_c),
        .out_valid  (s1_valid),
        .out_data   (s1_pl),
        .out_ready  (s2_ready_c)
    );

    vpe_elastic_reg #(.WIDTH($bits(s2_t))) u_s2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (frame_clear),
        .in_valid   (s1_valid),
        .in_data    (s2_in_c),
        .in_ready_c (s2_ready_c),
        .out_valid  (bus.out_valid),
        .out_data   (s2_pl),
        .out_ready  (bus.out_ready)
    );

    // Beat index, bias table and sticky saturation flag next state.
    always_comb begin
        idx_d      = idx_q;
        bias_d     = bias_q;
        sat_flag_d = sat_flag_q;
        if (frame_clear) begin
            idx_d = '0;
        end else if (accept_c) begin
            idx_d = (idx_q == IDX_W'(BATCH_SIZE - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        if (bias_wr_en) begin
            bias_d[bias_wr_idx] = bias_wr_data;
        end
        if (sat_evt_c) begin
            sat_flag_d = 1'b1;
        end else if (sat_clear) begin
            sat_flag_d = 1'b0;
        end
    end

    // Index, bias and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            sat_flag_q <= 1'b0;
            for (int i = 0; i < int'(BATCH_SIZE); i++) begin
                bias_q[i] <= '0;
            end
        end else begin
            idx_q      <= idx_d;
            sat_flag_q <= sat_flag_d;
            bias_q     <= bias_d;
        end
    end

`ifdef VPE_REQUANT_STATS_EN
    logic [STAT_W-1:0] sat_cnt_q, sat_cnt_d;

    // Saturating event counter; a clear coinciding with an event leaves 1.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_evt_c) begin
            if (sat_clear) begin
                sat_cnt_d = STAT_W'(1);
            end else if (sat_cnt_q != '1) begin
                sat_cnt_d = sat_cnt_q + STAT_W'(1);
            end
        end else if (sat_clear) begin
            sat_cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_count = sat_cnt_q;
`else
    assign sat_count = '0;
`endif
endmodule

// File: tb/tb_vpe_requant_stage.sv
// Self-checking bench for vpe_requant_stage: directed cases plus random traffic.
module tb_vpe_requant_stage;
    localparam int PW = 32;
    localparam int OW = 8;
    localparam int BS = 16;
    localparam int SW = 5;
    localparam int IW = 4;
`ifdef VPE_REQUANT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          frame_clear;
    logic [SW-1:0] cfg_shift;
    logic          cfg_relu_en;
    logic          bias_wr_en;
    logic [IW-1:0] bias_wr_idx;
    logic [PW-1:0] bias_wr_data;
    logic          sat_flag;
    logic          sat_clear;
    logic [15:0]   sat_count;

    vpe_requant_stage_if #(.PSUM_WIDTH(PW), .O_WIDTH(OW), .IDX_W(IW)) bus ();

    vpe_requant_stage #(
        .PSUM_WIDTH(PW), .O_WIDTH(OW), .BATCH_SIZE(BS), .SHIFT_WIDTH(SW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_clear  (frame_clear),
        .cfg_shift    (cfg_shift),
        .cfg_relu_en  (cfg_relu_en),
        .bias_wr_en   (bias_wr_en),
        .bias_wr_idx  (bias_wr_idx),
        .bias_wr_data (bias_wr_data),
        .bus          (bus),
        .sat_flag     (sat_flag),
        .sat_clear    (sat_clear),
        .sat_count    (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint data;
        int     idx;
        bit     sat;
        int     cyc;
    } exp_t;

    exp_t        sbq[$];
    int          bias_m[BS];
    int          idx_m;
    bit          flag_m;
    int          cnt_m;
    int          checks;
    int          errors;
    int          cyc;
    int          n_xfer;
    bit          chk_lat;
    bit          acc_seen;
    logic        last_in_ready;
    logic        last_out_valid;
    longint      last_data;
    int          last_idx;
    bit          stall_prev;
    logic [OW-1:0] prev_data;
    logic [IW-1:0] prev_idx;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: exact floor((x + 2^(s-1)) / 2^s), ReLU, clamp.
    function automatic exp_t model(input int din, input int b, input int sh, input bit relu);
        exp_t   e;
        longint s, num, d, q, hi, lo;
        hi  = (longint'(1) << (OW - 1)) - 1;
        lo  = -hi - 1;
        s   = longint'(din) + longint'(b);
        d   = longint'(1) << sh;
        num = s + d / 2;
        q   = num / d;
        if ((num % d) != 0 && num < 0) q = q - 1;
        if (relu && q < 0) q = 0;
        e.sat  = (q > hi) || (q < lo);
        e.data = (q > hi) ? hi : (q < lo) ? lo : q;
        e.idx  = 0;
        e.cyc  = 0;
        return e;
    endfunction

    // One clock: observe at negedge, update model, return just after posedge.
    task automatic tick();
        exp_t e;
        bit   acc, xfer;
        @(negedge clk);
        cyc++;
        acc            = bus.in_valid && bus.in_ready;
        xfer           = bus.out_valid && bus.out_ready;
        acc_seen       = acc;
        last_in_ready  = bus.in_ready;
        last_out_valid = bus.out_valid;
        if (frame_clear) chk("clear_in_ready", 64'(bus.in_ready), 0);
        if (stall_prev) begin
            chk("stall_data", 64'(bus.out_data), 64'(prev_data));
            chk("stall_idx", 64'(bus.out_idx), 64'(prev_idx));
        end
        chk("sat_flag", 64'(sat_flag), 64'(flag_m));
        chk("sat_count", 64'(sat_count), STATS ? 64'(cnt_m) : 64'(0));
        e.sat = 1'b0;
        if (xfer) begin
            n_xfer++;
            if (sbq.size() == 0) begin
                chk("unexpected_beat", 64'(bus.out_valid), 0);
            end else begin
                e = sbq.pop_front();
                chk("out_data", 64'($signed(bus.out_data)), e.data);
                chk("out_idx", 64'(bus.out_idx), 64'(e.idx));
                if (chk_lat) chk("latency", 64'(cyc - e.cyc), 2);
                last_data = longint'($signed(bus.out_data));
                last_idx  = int'(bus.out_idx);
            end
        end
        if (xfer && e.sat) begin
            flag_m = 1'b1;
            cnt_m  = sat_clear ? 1 : (cnt_m == 65535 ? 65535 : cnt_m + 1);
        end else if (sat_clear) begin
            flag_m = 1'b0;
            cnt_m  = 0;
        end
        if (frame_clear) begin
            sbq.delete();
            idx_m = 0;
        end else if (acc) begin
            e     = model($signed(bus.in_data), bias_m[idx_m], int'(cfg_shift), cfg_relu_en);
            e.idx = idx_m;
            e.cyc = cyc;
            sbq.push_back(e);
            idx_m = (idx_m + 1) % BS;
        end
        if (bias_wr_en) bias_m[bias_wr_idx] = $signed(bias_wr_data);
        stall_prev = bus.out_valid && !bus.out_ready && !frame_clear;
        prev_data  = bus.out_data;
        prev_idx   = bus.out_idx;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (acc_seen) break;
        end
        chk("accept", 64'(acc_seen), 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 60 && sbq.size() > 0; i++) tick();
        chk("drain_empty", 64'(sbq.size()), 0);
    endtask

    initial begin
        int n0;
        int k;
        checks = 0; errors = 0; cyc = 0; n_xfer = 0;
        idx_m = 0; flag_m = 0; cnt_m = 0; chk_lat = 0; stall_prev = 0;
        foreach (bias_m[i]) bias_m[i] = 0;
        rst_n = 1'b0; frame_clear = 1'b0; cfg_shift = '0; cfg_relu_en = 1'b0;
        bias_wr_en = 1'b0; bias_wr_idx = '0; bias_wr_data = '0; sat_clear = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;

        // Reset values
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 0);
        chk("rst_out_valid", 64'(bus.out_valid), 0);
        chk("rst_out_data", 64'(bus.out_data), 0);
        chk("rst_out_idx", 64'(bus.out_idx), 0);
        chk("rst_sat_flag", 64'(sat_flag), 0);
        chk("rst_sat_count", 64'(sat_count), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Bias add and rounding shift with 2-cycle latency
        chk_lat = 1'b1;
        bias_wr_en = 1'b1; bias_wr_idx = 4'd0; bias_wr_data = 32'd100;
        tick();
        bias_wr_en = 1'b0;
        cfg_shift = 5'd4;
        beat(1500);
        drain();
        chk("t1_data", last_data, 100);
        chk("t1_idx", 64'(last_idx), 0);

        // Negative rounding, ReLU, and same-cycle bias write uses old value
        cfg_shift = 5'd3;
        bias_wr_en = 1'b1; bias_wr_idx = 4'd1; bias_wr_data = 32'd5000;
        beat(-1000);
        bias_wr_en = 1'b0;
        drain();
        chk("t2_relu_off", last_data, -125);
        cfg_relu_en = 1'b1;
        beat(-1000);
        drain();
        chk("t2_relu_on", last_data, 0);
        chk("t2_no_sat", 64'(sat_flag), 0);

        // Positive and negative saturation, then clear
        cfg_relu_en = 1'b0;
        cfg_shift = 5'd0;
        beat(100000);
        drain();
        chk("t3_hi", last_data, 127);
        chk("t3_flag", 64'(sat_flag), 1);
        beat(-100000);
        drain();
        chk("t3_lo", last_data, -128);
        chk("t3_count", 64'(sat_count), STATS ? 64'(2) : 64'(0));
        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        tick();
        chk("t3_flag_clr", 64'(sat_flag), 0);
        chk("t3_count_clr", 64'(sat_count), 0);

        // 17 back-to-back beats: index wrap, no bubbles
        frame_clear = 1'b1;
        tick();
        frame_clear = 1'b0;
        n0 = n_xfer;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.in_data = i * 3 - 20;
            tick();
            chk("t4_accept", 64'(acc_seen), 1);
        end
        bus.in_valid = 1'b0;
        repeat (2) tick();
        chk("t4_xfers", 64'(n_xfer - n0), 17);
        chk("t4_last_idx", 64'(last_idx), 0);
        drain();

        // Backpressure: 4 beats with out_ready low for 5 cycles
        chk_lat = 1'b0;
        n0 = n_xfer;
        k = 0;
        for (int t = 0; t < 40 && (k < 4 || sbq.size() > 0); t++) begin
            bus.out_ready = (t >= 5);
            bus.in_valid  = (k < 4);
            bus.in_data   = 11 * k + 7;
            tick();
            if (t == 2) begin
                chk("t5_in_ready_low", 64'(last_in_ready), 0);
                chk("t5_two_held", 64'(k), 2);
            end
            if (acc_seen) k++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        chk("t5_xfers", 64'(n_xfer - n0), 4);
        chk("t5_empty", 64'(sbq.size()), 0);

        // frame_clear with two beats in flight
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 33;
        repeat (2) tick();
        bus.in_valid = 1'b0;
        frame_clear = 1'b1;
        tick();
        frame_clear = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("t6_out_valid", 64'(last_out_valid), 0);
        beat(9);
        drain();
        chk("t6_idx", 64'(last_idx), 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            int sel;
            sel = int'($urandom_range(0, 2));
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = (sel == 0) ? $urandom() :
                            (sel == 1) ? 32'($signed($urandom_range(0, 4000)) - 2000) :
                                         32'($signed($urandom_range(0, 400000)) - 200000);
            cfg_shift     = SW'($urandom_range(0, 31));
            cfg_relu_en   = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bias_wr_en    = ($urandom_range(0, 7) == 0);
            bias_wr_idx   = IW'($urandom_range(0, BS - 1));
            bias_wr_data  = ($urandom_range(0, 3) == 0) ? $urandom() :
                            32'($signed($urandom_range(0, 10000)) - 5000);
            sat_clear     = ($urandom_range(0, 15) == 0);
            frame_clear   = ($urandom_range(0, 63) == 0);
            tick();
        end
        bias_wr_en = 1'b0; sat_clear = 1'b0; frame_clear = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        // Asynchronous reset mid-stream
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 100000;
        cfg_shift = 5'd0;
        cfg_relu_en = 1'b0;
        repeat (2) tick();
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 64'(bus.out_valid), 0);
        chk("ar_in_ready", 64'(bus.in_ready), 0);
        chk("ar_out_data", 64'(bus.out_data), 0);
        chk("ar_out_idx", 64'(bus.out_idx), 0);
        chk("ar_sat_flag", 64'(sat_flag), 0);
        chk("ar_sat_count", 64'(sat_count), 0);
        sbq.delete();
        idx_m = 0; flag_m = 0; cnt_m = 0; stall_prev = 0;
        foreach (bias_m[i]) bias_m[i] = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        chk_lat = 1'b1;
        beat(-7);
        drain();
        chk("ar_post_data", last_data, -7);
        chk("ar_post_idx", 64'(last_idx), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
